fli_result_queue: RTL and testbench
===================================

# fli_result_queue

Registered result stage directly downstream of the float-immediate generator (`fli`) in the FPU. It accepts FLI.S/D/H/Q requests from decode with a valid/ready handshake, drives `fli` combinationally, and captures the NaN-boxed immediate with its destination tag into a small FIFO. It presents those entries to the FP register-file write arbiter with a second valid/ready handshake. Requests whose format is not enabled are rejected, and the stage keeps a saturating count of retired FLI writes.

## Interface
Parameters:
- `FLEN`, 64, FP register width; must be ≥ the widest enabled format.
- `DEPTH`, 2, number of FIFO entries; power of two, ≥ 2.
- `ZFH_SUPPORTED`, 0, half format enabled.
- `D_SUPPORTED`, 1, double format enabled.
- `Q_SUPPORTED`, 0, quad format enabled.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `FlushE`  in  1  pipeline flush; discards all queued entries.
- `ReqValid`  in  1  decode presents an FLI request.
- `ReqReady`  out  1  stage can accept a request.
- `ReqRs1`  in  5  immediate index.
- `ReqFmt`  in  2  format: 00 = S, 01 = D, 10 = H, 11 = Q.
- `ReqRd`  in  5  destination FP register.
- `FliRs1`  out  5  to `fli`.
- `FliFmt`  out  2  to `fli`.
- `FliImm`  in  FLEN  from `fli`.
- `WbValid`  out  1  head entry valid.
- `WbReady`  in  1  write arbiter accepts the head entry.
- `WbData`  out  FLEN  head immediate.
- `WbRd`  out  5  head destination.
- `IllegalFmt`  out  1  one-cycle pulse for a rejected request.
- `FliCount`  out  16  retired-write counter; saturates at 16'hFFFF.

## Operation
- `FliRs1` and `FliFmt` are combinational copies of `ReqRs1` and `ReqFmt`. `fli` is combinational, so `FliImm` is sampled in the same cycle.
- Format enable: fmt 00 is always legal. Fmt 01 is legal only if `D_SUPPORTED`, fmt 10 only if `ZFH_SUPPORTED`, fmt 11 only if `Q_SUPPORTED`.
- Accept condition: `ReqValid & ReqReady`.
- `ReqReady = ~full`. There is no pop-to-push bypass when the FIFO is full.
- Legal accept: push {`FliImm`, `ReqRd`} at the write pointer.
- Illegal accept: the handshake completes and nothing is pushed. `IllegalFmt` is registered high for the next cycle only.
- Pop condition: `WbValid & WbReady`. On pop, `FliCount` increments unless it is already 16'hFFFF.
- `WbValid = ~empty`. `WbData` and `WbRd` show the head entry. They are don't-care when `WbValid` is 0 but must not be X after reset.
- Pointers are log2(DEPTH) bits plus one wrap bit. `full` and `empty` are derived from the pointers. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle:
  - Non-empty, non-full: both happen; occupancy is unchanged.
  - Empty: only the push happens; no bypass, so the entry is visible next cycle.
  - Full: the push is blocked by `ReqReady`.
- `FlushE` has priority over everything:
  - Both pointers reset to 0.
  - A same-cycle push and pop are both cancelled. `FliCount` does not count a popped entry in that cycle.
  - `IllegalFmt` is not raised for a request presented in the flush cycle.
- `FliCount` is not cleared by flush, only by reset.

## Timing
- Latency: an accept in cycle N gives `WbValid` = 1 in cycle N+1 (FIFO previously empty).
- Throughput: one accept and one retire per cycle in steady state.
- `IllegalFmt`: high in cycle N+1 for a rejected accept in cycle N.
- Reset (`reset_n` low, asynchronous): pointers = 0, storage = 0, `WbValid` = 0, `ReqReady` = 1, `IllegalFmt` = 0, `FliCount` = 0. `WbData` and `WbRd` read 0.
- Reset asserted mid-operation drops all entries immediately. The first accept is possible in the first cycle after deassertion.
- `WbValid`, `WbData` and `WbRd` must stay stable while `WbValid & ~WbReady`.

## Structure
- Package `fli_pkg`:
  - Format localparams `FMT_S`, `FMT_D`, `FMT_H`, `FMT_Q`.
  - `typedef struct packed { logic [FLEN-1:0] imm; logic [4:0] rd; } fli_entry_t`, parameterised through a package parameter or macro.
- Instantiate `fli` inside this block as the single sub-module, driven by `FliRs1` and `FliFmt`. The `FliImm` port remains for bench observation and may be tied internally.
- Storage is a DEPTH-entry register array; no RAM macro.

## Test plan
- Legal formats (FLEN = 64, D_SUPPORTED = 1, ZFH_SUPPORTED = 1):
  - Rs1 = 16, fmt 00, Rd = 3 -> next cycle `WbData` = 64'hFFFFFFFF3F800000, `WbRd` = 3.
  - Rs1 = 0, fmt 01 -> `WbData` = 64'hBFF0000000000000.
  - Rs1 = 29, fmt 10 -> `WbData` = 64'hFFFFFFFFFFFF7C00.
- Illegal format: fmt 11 with Q_SUPPORTED = 0 -> `ReqReady` = 1, `IllegalFmt` = 1 for exactly one cycle, `WbValid` stays 0, `FliCount` unchanged.
- Backpressure: `WbReady` = 0, three back-to-back requests (Rs1 = 20, 21, 22, fmt 00):
  - `ReqReady` drops after the 2nd accept; the 3rd request is held.
  - Release `WbReady` -> outputs 40000000, 40200000, 40400000 (NaN-boxed) in order; `FliCount` = 3.
- Simultaneous push and pop at occupancy 1, repeated for 8 cycles -> occupancy stays 1, pointers wrap correctly, data stays in order.
- Flush with 2 entries queued while `WbReady` = 1 and a request is valid -> next cycle `WbValid` = 0, `FliCount` unchanged, nothing enqueued.
- Async reset pulse mid-stream -> `WbValid` = 0, `FliCount` = 0, `ReqReady` = 1 immediately, with no clock edge required.

Source files
------------

// File: rtl/fli_result_queue_pkg.sv
// Shared types and constants for the FLI result stage and the fli immediate generator.
package fli_pkg;

    localparam logic [1:0] FMT_S = 2'b00;
    localparam logic [1:0] FMT_D = 2'b01;
    localparam logic [1:0] FMT_H = 2'b10;
    localparam logic [1:0] FMT_Q = 2'b11;

    parameter int unsigned FLI_FLEN = 64;

    typedef struct packed {
        logic [FLI_FLEN-1:0] imm;
        logic [4:0]          rd;
    } fli_entry_t;

    typedef enum logic [1:0] {
        IMM_NORM,
        IMM_MINNORM,
        IMM_INF,
        IMM_NAN
    } imm_kind_e;

    function automatic logic fmt_enabled(input logic [1:0] fmt, input logic zfh,
                                         input logic d, input logic q);
        logic ok;
        case (fmt)
            FMT_S:   ok = 1'b1;
            FMT_D:   ok = d;
            FMT_H:   ok = zfh;
            default: ok = q;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fli_result_queue_fli.sv
// Combinational FLI immediate generator: table index + format -> NaN-boxed constant.
module fli
    import fli_pkg::*;
#(
    parameter int unsigned FLEN = 64
) (
    input  logic [4:0]      rs1,
    input  logic [1:0]      fmt,
    output logic [FLEN-1:0] imm
);

    imm_kind_e    kind;
    logic         sign;
    logic [1:0]   frac;
    int           e;
    int           ew;
    int           mw;
    int           bias;
    int           biased;
    int           width;
    logic [127:0] exp_ones;
    logic [127:0] raw;

    // Every table entry is +/-1.ff * 2^e with a 2-bit fraction, or a special value.
    always_comb begin
        kind = IMM_NORM;
        sign = 1'b0;
        frac = 2'b00;
        e    = 0;
        case (rs1)
            5'd0:  sign = 1'b1;
            5'd1:  kind = IMM_MINNORM;
            5'd2:  e = -16;
            5'd3:  e = -15;
            5'd4:  e = -8;
            5'd5:  e = -7;
            5'd6:  e = -4;
            5'd7:  e = -3;
            5'd8, 5'd9, 5'd10, 5'd11: begin
                e    = -2;
                frac = rs1[1:0];
            end
            5'd12, 5'd13, 5'd14, 5'd15: begin
                e    = -1;
                frac = rs1[1:0];
            end
            5'd16, 5'd17, 5'd18, 5'd19: begin
                e    = 0;
                frac = rs1[1:0];
            end
            5'd20, 5'd21, 5'd22: begin
                e    = 1;
                frac = rs1[1:0];
            end
            5'd23: e = 2;
            5'd24: e = 3;
            5'd25: e = 4;
            5'd26: e = 7;
            5'd27: e = 8;
            5'd28: e = 15;
            5'd29: e = 16;
            5'd30: kind = IMM_INF;
            default: kind = IMM_NAN;
        endcase
    end

    always_comb begin
        case (fmt)
            FMT_S: begin
                ew = 8;
                mw = 23;
            end
            FMT_D: begin
                ew = 11;
                mw = 52;
            end
            FMT_H: begin
                ew = 5;
                mw = 10;
            end
            default: begin
                ew = 15;
                mw = 112;
            end
        endcase
        bias     = (1 << (ew - 1)) - 1;
        biased   = e + bias;
        width    = 1 + ew + mw;
        exp_ones = ((128'd1 << ew) - 128'd1) << mw;
        case (kind)
            IMM_MINNORM: raw = 128'd1 << mw;
            IMM_INF:     raw = exp_ones;
            IMM_NAN:     raw = exp_ones | (128'd1 << (mw - 1));
            default: begin
                // Out-of-range exponents only occur in half: overflow -> inf, underflow -> subnormal.
                if (biased >= (1 << ew) - 1) begin
                    raw = exp_ones;
                end else if (biased <= 0) begin
                    raw = 128'd1 << (mw + biased - 1);
                end else begin
                    raw = (128'(biased) << mw) | (128'(frac) << (mw - 2));
                end
                raw = raw | (128'(sign) << (ew + mw));
            end
        endcase
        for (int unsigned i = 0; i < FLEN; i++) begin
            imm[i] = (i < unsigned'(width)) ? raw[i[6:0]] : 1'b1;
        end
    end

endmodule

// File: rtl/fli_result_queue.sv
// FLI result stage: accepts decode requests, queues NaN-boxed immediates, retires to FP write arbiter.
module fli_result_queue
    import fli_pkg::*;
#(
    parameter int unsigned FLEN          = 64,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned ZFH_SUPPORTED = 0,
    parameter int unsigned D_SUPPORTED   = 1,
    parameter int unsigned Q_SUPPORTED   = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            FlushE,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [4:0]      ReqRs1,
    input  logic [1:0]      ReqFmt,
    input  logic [4:0]      ReqRd,
    output logic [4:0]      FliRs1,
    output logic [1:0]      FliFmt,
    input  logic [FLEN-1:0] FliImm,
    output logic            WbValid,
    input  logic            WbReady,
    output logic [FLEN-1:0] WbData,
    output logic [4:0]      WbRd,
    output logic            IllegalFmt,
    output logic [15:0]     FliCount
);

    localparam int unsigned AW = $clog2(DEPTH);

    fli_entry_t      mem_q [DEPTH];
    fli_entry_t      mem_d [DEPTH];
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic            illegal_q, illegal_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [FLEN-1:0] imm;
    logic            full, empty, fmt_ok, accept, push, pop;
    logic            fli_imm_unused;

    assign FliRs1 = ReqRs1;
    assign FliFmt = ReqFmt;

    // The internal generator supplies the data; the FliImm port is kept only for observation.
    fli #(.FLEN(FLEN)) u_fli (
        .rs1 (FliRs1),
        .fmt (FliFmt),
        .imm (imm)
    );
    assign fli_imm_unused = ^FliImm;

    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign ReqReady   = ~full;
    assign WbValid    = ~empty;
    assign WbData     = mem_q[rptr_q[AW-1:0]].imm;
    assign WbRd       = mem_q[rptr_q[AW-1:0]].rd;
    assign IllegalFmt = illegal_q;
    assign FliCount   = cnt_q;

    always_comb begin
        fmt_ok    = fmt_enabled(ReqFmt, ZFH_SUPPORTED != 0, D_SUPPORTED != 0, Q_SUPPORTED != 0);
        accept    = ReqValid & ReqReady;
        push      = accept & fmt_ok & ~FlushE;
        pop       = WbValid & WbReady & ~FlushE;
        illegal_d = accept & ~fmt_ok & ~FlushE;

        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = '{imm: imm, rd: ReqRd};
        end

        if (FlushE) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + {{AW{1'b0}}, push};
            rptr_d = rptr_q + {{AW{1'b0}}, pop};
        end

        cnt_d = (pop && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fli_result_queue.sv
// Directed bench for fli_result_queue with a queue-based reference model checked every cycle.
module tb_fli_result_queue;

    localparam int unsigned FLEN  = 64;
    localparam int unsigned DEPTH = 2;
    localparam bit ZFH = 1'b1;
    localparam bit DSUP = 1'b1;
    localparam bit QSUP = 1'b0;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            FlushE = 1'b0;
    logic            ReqValid = 1'b0;
    logic [4:0]      ReqRs1 = '0;
    logic [1:0]      ReqFmt = '0;
    logic [4:0]      ReqRd = '0;
    logic [FLEN-1:0] FliImm = '0;
    logic            WbReady = 1'b0;
    logic            ReqReady, WbValid, IllegalFmt;
    logic [4:0]      FliRs1, WbRd;
    logic [1:0]      FliFmt;
    logic [FLEN-1:0] WbData;
    logic [15:0]     FliCount;

    fli_result_queue #(
        .FLEN(FLEN), .DEPTH(DEPTH), .ZFH_SUPPORTED(1), .D_SUPPORTED(1), .Q_SUPPORTED(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .FlushE(FlushE),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqRs1(ReqRs1), .ReqFmt(ReqFmt), .ReqRd(ReqRd),
        .FliRs1(FliRs1), .FliFmt(FliFmt), .FliImm(FliImm),
        .WbValid(WbValid), .WbReady(WbReady), .WbData(WbData), .WbRd(WbRd),
        .IllegalFmt(IllegalFmt), .FliCount(FliCount)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] imm;
        logic [4:0]  rd;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_cnt = 0;
    logic        m_ill = 1'b0;

    function automatic real fli_value(input logic [4:0] idx);
        case (idx)
            5'd0:  return -1.0;
            5'd2:  return 2.0 ** -16.0;
            5'd3:  return 2.0 ** -15.0;
            5'd4:  return 2.0 ** -8.0;
            5'd5:  return 2.0 ** -7.0;
            5'd6:  return 0.0625;
            5'd7:  return 0.125;
            5'd8:  return 0.25;
            5'd9:  return 0.3125;
            5'd10: return 0.375;
            5'd11: return 0.4375;
            5'd12: return 0.5;
            5'd13: return 0.625;
            5'd14: return 0.75;
            5'd15: return 0.875;
            5'd16: return 1.0;
            5'd17: return 1.25;
            5'd18: return 1.5;
            5'd19: return 1.75;
            5'd20: return 2.0;
            5'd21: return 2.5;
            5'd22: return 3.0;
            5'd23: return 4.0;
            5'd24: return 8.0;
            5'd25: return 16.0;
            5'd26: return 128.0;
            5'd27: return 256.0;
            5'd28: return 32768.0;
            5'd29: return 65536.0;
            default: return 0.0;
        endcase
    endfunction

    function automatic logic [63:0] model_imm(input logic [4:0] rs1, input logic [1:0] fmt);
        real         v;
        logic [63:0] d;
        int          e;
        logic        s;
        logic [1:0]  m;
        if (rs1 == 5'd1) begin
            case (fmt)
                2'b00:   return {32'hFFFFFFFF, 32'h00800000};
                2'b01:   return 64'h0010000000000000;
                default: return {48'hFFFFFFFFFFFF, 16'h0400};
            endcase
        end
        if (rs1 == 5'd30) begin
            case (fmt)
                2'b00:   return {32'hFFFFFFFF, 32'h7F800000};
                2'b01:   return 64'h7FF0000000000000;
                default: return {48'hFFFFFFFFFFFF, 16'h7C00};
            endcase
        end
        if (rs1 == 5'd31) begin
            case (fmt)
                2'b00:   return {32'hFFFFFFFF, 32'h7FC00000};
                2'b01:   return 64'h7FF8000000000000;
                default: return {48'hFFFFFFFFFFFF, 16'h7E00};
            endcase
        end
        v = fli_value(rs1);
        d = $realtobits(v);
        s = d[63];
        e = int'(d[62:52]) - 1023;
        m = d[51:50];
        case (fmt)
            2'b00: return {32'hFFFFFFFF, s, 8'(e + 127), m, 21'd0};
            2'b01: return d;
            default: begin
                if (e > 15) return {48'hFFFFFFFFFFFF, 16'h7C00};
                if (e < -14) return {48'hFFFFFFFFFFFF, s, 15'(int'(v * (2.0 ** 24.0)))};
                return {48'hFFFFFFFFFFFF, s, 5'(e + 15), m, 8'd0};
            end
        endcase
    endfunction

    function automatic bit legal(input logic [1:0] fmt);
        case (fmt)
            2'b00:   return 1'b1;
            2'b01:   return DSUP;
            2'b10:   return ZFH;
            default: return QSUP;
        endcase
    endfunction

    // Inputs change 1 time unit after a rising edge, so at the falling edge they are the
    // values the next rising edge will sample: compare current state, then advance the model.
    always @(negedge clk) begin
        bit acc;
        bit pop_c;
        if (!reset_n) begin
            mq.delete();
            m_cnt = 0;
            m_ill = 1'b0;
        end else begin
            check("ReqReady", 64'(ReqReady), 64'(mq.size() < DEPTH));
            check("WbValid", 64'(WbValid), 64'(mq.size() > 0));
            check("IllegalFmt", 64'(IllegalFmt), 64'(m_ill));
            check("FliCount", 64'(FliCount), 64'(m_cnt));
            if (mq.size() > 0) begin
                check("WbData", WbData, mq[0].imm);
                check("WbRd", 64'(WbRd), 64'(mq[0].rd));
            end
            acc = ReqValid && (mq.size() < DEPTH);
            if (FlushE) begin
                mq.delete();
                m_ill = 1'b0;
            end else begin
                pop_c = WbReady && (mq.size() > 0);
                m_ill = acc && !legal(ReqFmt);
                if (pop_c) begin
                    void'(mq.pop_front());
                    if (m_cnt < 65535) m_cnt++;
                end
                if (acc && legal(ReqFmt)) begin
                    mq.push_back('{imm: model_imm(ReqRs1, ReqFmt), rd: ReqRd});
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] rs1, input logic [1:0] fmt, input logic [4:0] rd);
        ReqValid = 1'b1;
        ReqRs1   = rs1;
        ReqFmt   = fmt;
        ReqRd    = rd;
    endtask

    initial begin
        #1;
        check("rst_WbValid", 64'(WbValid), 64'd0);
        check("rst_ReqReady", 64'(ReqReady), 64'd1);
        check("rst_WbData", WbData, 64'd0);
        check("rst_WbRd", 64'(WbRd), 64'd0);
        check("rst_FliCount", 64'(FliCount), 64'd0);
        check("rst_IllegalFmt", 64'(IllegalFmt), 64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step();

        // Legal formats S, D, H
        req(5'd16, 2'b00, 5'd3);
        step();
        ReqValid = 1'b0;
        check("s_one_valid", 64'(WbValid), 64'd1);
        check("s_one_data", WbData, 64'hFFFFFFFF3F800000);
        check("s_one_rd", 64'(WbRd), 64'd3);
        WbReady = 1'b1;
        step();
        WbReady = 1'b0;
        check("s_one_count", 64'(FliCount), 64'd1);

        req(5'd0, 2'b01, 5'd4);
        step();
        ReqValid = 1'b0;
        check("d_neg1_data", WbData, 64'hBFF0000000000000);
        WbReady = 1'b1;
        step();
        WbReady = 1'b0;

        req(5'd29, 2'b10, 5'd5);
        step();
        ReqValid = 1'b0;
        check("h_inf_data", WbData, 64'hFFFFFFFFFFFF7C00);
        WbReady = 1'b1;
        step();
        WbReady = 1'b0;
        check("legal_count", 64'(FliCount), 64'd3);

        // Illegal quad request
        req(5'd5, 2'b11, 5'd6);
        check("ill_ready", 64'(ReqReady), 64'd1);
        step();
        ReqValid = 1'b0;
        check("ill_pulse", 64'(IllegalFmt), 64'd1);
        check("ill_novalid", 64'(WbValid), 64'd0);
        step();
        check("ill_pulse_end", 64'(IllegalFmt), 64'd0);
        check("ill_count", 64'(FliCount), 64'd3);

        // Backpressure with three back-to-back requests
        req(5'd20, 2'b00, 5'd7);
        step();
        req(5'd21, 2'b00, 5'd8);
        step();
        check("bp_full", 64'(ReqReady), 64'd0);
        req(5'd22, 2'b00, 5'd9);
        step();
        check("bp_held", 64'(ReqReady), 64'd0);
        check("bp_head0", WbData, 64'hFFFFFFFF40000000);
        WbReady = 1'b1;
        step();
        check("bp_head1", WbData, 64'hFFFFFFFF40200000);
        check("bp_ready", 64'(ReqReady), 64'd1);
        step();
        ReqValid = 1'b0;
        check("bp_head2", WbData, 64'hFFFFFFFF40400000);
        check("bp_rd2", 64'(WbRd), 64'd9);
        step();
        WbReady = 1'b0;
        check("bp_empty", 64'(WbValid), 64'd0);
        check("bp_count", 64'(FliCount), 64'd6);

        // Simultaneous push and pop at occupancy 1
        req(5'd16, 2'b00, 5'd1);
        step();
        WbReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req(5'(17 + i), 2'(i % 2), 5'(i + 2));
            step();
            check("pp_valid", 64'(WbValid), 64'd1);
            check("pp_ready", 64'(ReqReady), 64'd1);
        end
        ReqValid = 1'b0;
        step();
        WbReady = 1'b0;
        check("pp_drained", 64'(WbValid), 64'd0);
        check("pp_count", 64'(FliCount), 64'd15);

        // Flush with two entries queued, pop ready and a request valid
        req(5'd16, 2'b00, 5'd1);
        step();
        req(5'd17, 2'b00, 5'd2);
        step();
        check("fl_full", 64'(ReqReady), 64'd0);
        req(5'd18, 2'b00, 5'd3);
        FlushE  = 1'b1;
        WbReady = 1'b1;
        step();
        FlushE   = 1'b0;
        ReqValid = 1'b0;
        WbReady  = 1'b0;
        check("fl_empty", 64'(WbValid), 64'd0);
        check("fl_count", 64'(FliCount), 64'd15);
        check("fl_ready", 64'(ReqReady), 64'd1);
        step();
        check("fl_still_empty", 64'(WbValid), 64'd0);

        req(5'd16, 2'b00, 5'd1);
        step();
        req(5'd3, 2'b11, 5'd2);
        FlushE  = 1'b1;
        WbReady = 1'b1;
        step();
        FlushE   = 1'b0;
        ReqValid = 1'b0;
        WbReady  = 1'b0;
        check("fl_no_illegal", 64'(IllegalFmt), 64'd0);
        check("fl2_empty", 64'(WbValid), 64'd0);
        check("fl2_count", 64'(FliCount), 64'd15);

        // Asynchronous reset mid-stream
        req(5'd25, 2'b00, 5'd4);
        step();
        ReqValid = 1'b0;
        check("ar_pre_valid", 64'(WbValid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(WbValid), 64'd0);
        check("ar_count", 64'(FliCount), 64'd0);
        check("ar_ready", 64'(ReqReady), 64'd1);
        check("ar_data", WbData, 64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        req(5'd16, 2'b10, 5'd5);
        step();
        ReqValid = 1'b0;
        check("ar_first_valid", 64'(WbValid), 64'd1);
        check("ar_first_data", WbData, 64'hFFFFFFFFFFFF3C00);
        WbReady = 1'b1;
        step();
        WbReady = 1'b0;
        check("ar_first_count", 64'(FliCount), 64'd1);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
